// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes plus the memory port signals of the arbiter
interface mem_port_arbiter_if #(
    parameter int n = 8
);
    logic         a_req, b_req;
    logic         a_we, b_we;
    logic         a_lock, b_lock;
    logic [n-1:0] a_addr, b_addr;
    logic [n-1:0] a_wdata, b_wdata;
    logic         a_gnt, b_gnt;
    logic         a_rvalid, b_rvalid;
    logic [n-1:0] a_rdata, b_rdata;
    logic         mem_wr_en;
    logic [n-1:0] mem_wr_addr, mem_wr_data, mem_rd_addr;
    logic [n-1:0] mem_rd_data;

    modport master (
        output a_req, b_req, a_we, b_we, a_lock, b_lock,
        output a_addr, b_addr, a_wdata, b_wdata, mem_rd_data,
        input  a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
        input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr
    );

    modport slave (
        input  a_req, b_req, a_we, b_we, a_lock, b_lock,
        input  a_addr, b_addr, a_wdata, b_wdata, mem_rd_data,
        output a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
        output mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory read/write port between two requesters
module mem_port_arbiter #(
    parameter int n        = 8,
    parameter int LOCK_MAX = 8
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

    logic         prio, owner_q, lock_q, rd_pend_a, rd_pend_b;
    logic [7:0]   cnt;
    logic [n-1:0] addr_q, wdata_q;
    logic         any, sel, hold, other_req, sel_we;
    logic [n-1:0] sel_addr, sel_wdata;

    // Pick the grantee (sel: 0 = A, 1 = B); a live lock under its limit overrides round-robin
    always_comb begin
        hold      = lock_q && (owner_q ? bus.b_req : bus.a_req) && (cnt < LOCK_LIM);
        any       = bus.a_req | bus.b_req;
        sel       = hold ? owner_q : (bus.a_req && bus.b_req) ? prio : bus.b_req;
        other_req = sel ? bus.a_req : bus.b_req;
        sel_we    = any & (sel ? bus.b_we : bus.a_we);
        sel_addr  = sel ? bus.b_addr : bus.a_addr;
        sel_wdata = sel ? bus.b_wdata : bus.a_wdata;
    end

    assign bus.a_gnt       = any & ~sel;
    assign bus.b_gnt       = any & sel;
    assign bus.mem_wr_en   = rst_n & sel_we;
    assign bus.mem_wr_addr = !rst_n ? '0 : any ? sel_addr : addr_q;
    assign bus.mem_wr_data = !rst_n ? '0 : any ? sel_wdata : wdata_q;
    assign bus.mem_rd_addr = bus.mem_wr_addr;
    assign bus.a_rvalid    = rd_pend_a;
    assign bus.b_rvalid    = rd_pend_b;
    assign bus.a_rdata     = bus.mem_rd_data;
    assign bus.b_rdata     = bus.mem_rd_data;

    // Arbitration history, lock streak counter, held bus values and read-return tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio      <= 1'b0;
            owner_q   <= 1'b0;
            lock_q    <= 1'b0;
            cnt       <= 8'd0;
            rd_pend_a <= 1'b0;
            rd_pend_b <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            rd_pend_a <= any & ~sel & ~bus.a_we;
            rd_pend_b <= any & sel & ~bus.b_we;
            if (any) begin
                owner_q <= sel;
                lock_q  <= sel ? bus.b_lock : bus.a_lock;
                prio    <= ~sel;
                cnt     <= !other_req ? 8'd0 : (sel != owner_q) ? 8'd1 : (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end else begin
                lock_q <= 1'b0;
                cnt    <= 8'd0;
            end
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the data memory's second read port and its single write port between the CPU load/store unit (requester A) and the DMA engine (requester B). It issues at most one memory access per cycle, chosen round-robin, with optional bus locking bounded by an anti-starvation limit. It drives the memory's wr_en/wr_addr/wr_data/rd_addr2 and routes rd_data2 back to the owning requester with a read-valid strobe. It sits between the two requesters and the 256-entry memory; read port 1 (instruction fetch) is not arbitrated.

## Interface
Parameters:
- n, 8: address and data width.
- LOCK_MAX, 8: maximum consecutive grants to one requester while the other is requesting (1..255).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_req, b_req  in  1  access request; held high until granted.
- a_we, b_we  in  1  1 = write, 0 = read; sampled with req.
- a_lock, b_lock  in  1  request that the grant stay with this requester on the next cycle.
- a_addr, b_addr  in  n  access address.
- a_wdata, b_wdata  in  n  write data.
- a_gnt, b_gnt  out  1  combinational grant; the access is performed this cycle.
- a_rvalid, b_rvalid  out  1  read data valid for the owning requester.
- a_rdata, b_rdata  out  n  read data; equals mem_rd_data, qualified by rvalid.
- mem_wr_en  out  1  to memory wr_en.
- mem_wr_addr, mem_wr_data  out  n  to memory write port.
- mem_rd_addr  out  n  to memory rd_addr2.
- mem_rd_data  in  n  from memory rd_data2; valid one cycle after the address is presented.

## Operation
- State: prio (1 bit, 0 = A preferred), owner_q (last granted requester), lock_q (previous grant carried lock), cnt (8 bits, consecutive grants to owner_q while the other requester was requesting), rd_pend_a and rd_pend_b (read issued last cycle).
- Grant decision, combinational, per cycle:
  - if lock_q, req[owner_q] is high, and cnt < LOCK_MAX: grant owner_q;
  - else if exactly one req is high: grant it;
  - else if both are high: grant the requester selected by prio;
  - else: no grant.
- At most one gnt is high per cycle; a gnt is never asserted without its req.
- The granted requester's addr/wdata drive mem_wr_addr/mem_wr_data and mem_rd_addr. mem_wr_en = gnt & we.
- With no grant: mem_wr_en = 0. Address and data outputs hold their last values; they must not toggle to X.
- Update on a grant:
  - owner_q <= granted requester; lock_q <= lock of the granted requester; prio <= the other requester.
  - cnt: increments, saturating at 255, if the grantee equals owner_q and the other req is high. It is set to 1 if the other req is high and the owner changed. Otherwise it resets to 0.
- With no grant: lock_q <= 0, cnt <= 0, prio unchanged.
- Read return: rd_pend_x <= gnt_x & ~we_x. Next cycle, x_rvalid = rd_pend_x and x_rdata = mem_rd_data.
- Write then read of the same address on consecutive cycles returns the new data. The write completes on the edge ending the grant cycle.
- A lock deasserted while its holder is granted releases arbitration on the following cycle.

## Timing
- Reset (rst_n low, asynchronous): prio = 0, owner_q = A, lock_q = 0, cnt = 0, rd_pend_a = rd_pend_b = 0.
  - Outputs during reset: a_rvalid = b_rvalid = 0, mem_wr_en = 0, gnt follows the combinational rule with lock inactive, and mem_wr_addr/mem_wr_data/mem_rd_addr = 0.
- Read latency: grant in cycle T, rvalid and data in cycle T+1.
- Write: committed at the end of cycle T; no response strobe.
- Throughput: one access per cycle; back-to-back reads overlap (grant T+1 coincides with rvalid from T).
- Reset mid-read: a pending rvalid is dropped; no spurious rvalid after rst_n rises.
- Requests asserted in the cycle rst_n deasserts are arbitrated normally; A wins a tie.

## Test plan
- Reset, then a_req read at address 0x10 (mem[0x10] = 0x5A) -> a_gnt in cycle T; a_rvalid = 1 and a_rdata = 0x5A in T+1; b_rvalid stays 0.
- Both requesters hold reads continuously, no lock -> grants alternate A, B, A, B; each rvalid follows its own grant by exactly one cycle.
- A writes 0x33 to 0x80, then reads 0x80 on the next cycle -> mem_wr_en pulses once; the read returns 0x33.
- A holds req+lock, B requests continuously, LOCK_MAX = 8 -> A is granted 8 consecutive cycles, then B is granted in cycle 9.
- b_req alone with b_we = 1, addr 0xFF, data 0xAA -> mem_wr_en = 1, mem_wr_addr = 0xFF, mem_wr_data = 0xAA; no rvalid on either side.
- Read granted, rst_n pulsed low in cycle T+1 before the edge -> a_rvalid = 0 immediately and remains 0; afterwards prio = A and the next simultaneous request grants A.
